seq_detect_param: RTL and testbench

Parameterised serial sequence detector. Flags a programmable N-bit pattern on a 1-bit input stream and counts matches.
- Selectable Mealy or Moore output timing.
- Selectable overlapping or non-overlapping detection.
- Sample-enable qualifier; runtime pattern reload.
- Sits between a serial bit source and control/status logic as the general replacement for fixed-pattern 4-state detectors.

---
 rtl/seq_detect_pkg.sv | 22 ++
 rtl/sat_counter.sv | 29 ++
 rtl/seq_detect_param.sv | 107 ++++++++++
 tb/tb_seq_detect_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// seq_detect_pkg : shared constants, FSM state type and width helper
// Revision : 1.0
// ============================================================================
package seq_detect_pkg;

  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Width needed to hold a fill count of 0..n-1; never narrower than 1 bit.
  function automatic int fill_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up counter that sticks at all ones, with registered sat flag
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] c_MAX = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
      sat <= (cnt == c_MAX - CNT_W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// seq_detect_param : programmable N-bit serial pattern detector, Mealy/Moore,
//                    overlapping or non-overlapping, with saturating match count
// Revision : 1.0
// ============================================================================
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int           N       = 4,
  parameter int           MODE    = MODE_MEALY,
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = 8,
  parameter logic [N-1:0] PAT_RST = 4'b1011
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             x_in,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             y_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int                c_FILL_W    = fill_width(N);
  localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(N - 2);

  state_t              r_state;
  logic [c_FILL_W-1:0] r_fill;
  logic [N-2:0]        r_hist;
  logic [N-1:0]        r_pattern;

  logic [N-1:0]        w_cand;
  logic                w_hit;

  // Oldest history bit lands in the MSB, lining up with pattern MSB.
  assign w_cand = {r_hist, x_in};
  assign w_hit  = en && !pat_load && (r_state == ARMED) && (w_cand == r_pattern);
  assign armed  = (r_state == ARMED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= FILL;
      r_fill    <= '0;
      r_hist    <= '0;
      r_pattern <= PAT_RST;
    end else if (pat_load) begin
      r_pattern <= pat_in;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= FILL;
    end else if (en) begin
      case (r_state)
        FILL: begin
          r_hist <= w_cand[N-2:0];
          r_fill <= r_fill + c_FILL_W'(1);
          if (r_fill == c_FILL_LAST) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (w_hit && (OVERLAP == 0)) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= FILL;
          end else begin
            r_hist <= w_cand[N-2:0];
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  generate
    if (MODE == MODE_MOORE) begin : g_moore
      logic r_y;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_y <= 1'b0;
        end else begin
          r_y <= w_hit;
        end
      end
      assign y_out = r_y;
    end else begin : g_mealy
      assign y_out = w_hit;
    end
  endgenerate

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_hit),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// tb_seq_detect_param : four detector variants on one stimulus stream, each
//                       checked against a bit-history reference model
// Revision : 1.0
// ============================================================================
module tb_seq_detect_param;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       x_in = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'd0;

  logic [3:0] y_v, armed_v, sat_v;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: numeric value and length of the valid history.
  int unsigned hv[4];
  int          hl[4];
  int          cntm[4];
  bit          prev[4];
  int          pat;

  always #5 clock = ~clock;

  seq_detect_param #(.N(4), .MODE(0), .OVERLAP(1), .CNT_W(8), .PAT_RST(4'b1011)) u0 (
    .clock(clock), .reset(reset), .en(en), .x_in(x_in), .pat_load(pat_load), .pat_in(pat_in),
    .y_out(y_v[0]), .match_cnt(cnt0), .cnt_sat(sat_v[0]), .armed(armed_v[0]));
  seq_detect_param #(.N(4), .MODE(0), .OVERLAP(0), .CNT_W(8), .PAT_RST(4'b1011)) u1 (
    .clock(clock), .reset(reset), .en(en), .x_in(x_in), .pat_load(pat_load), .pat_in(pat_in),
    .y_out(y_v[1]), .match_cnt(cnt1), .cnt_sat(sat_v[1]), .armed(armed_v[1]));
  seq_detect_param #(.N(4), .MODE(1), .OVERLAP(1), .CNT_W(8), .PAT_RST(4'b1011)) u2 (
    .clock(clock), .reset(reset), .en(en), .x_in(x_in), .pat_load(pat_load), .pat_in(pat_in),
    .y_out(y_v[2]), .match_cnt(cnt2), .cnt_sat(sat_v[2]), .armed(armed_v[2]));
  seq_detect_param #(.N(4), .MODE(1), .OVERLAP(0), .CNT_W(2), .PAT_RST(4'b1011)) u3 (
    .clock(clock), .reset(reset), .en(en), .x_in(x_in), .pat_load(pat_load), .pat_in(pat_in),
    .y_out(y_v[3]), .match_cnt(cnt3), .cnt_sat(sat_v[3]), .armed(armed_v[3]));

  function automatic bit is_moore(input int i);
    return (i >= 2);
  endfunction

  function automatic bit overlaps(input int i);
    return (i == 0) || (i == 2);
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 3) ? 3 : 255;
  endfunction

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph, input bit hit[4]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s y%0d", ph, i), int'(y_v[i]), int'(is_moore(i) ? prev[i] : hit[i]));
      check($sformatf("%s armed%0d", ph, i), int'(armed_v[i]), int'(hl[i] == N - 1));
      check($sformatf("%s cnt%0d", ph, i), get_cnt(i), cntm[i]);
      check($sformatf("%s sat%0d", ph, i), int'(sat_v[i]), int'(cntm[i] == cnt_max(i)));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 0; hl[i] = 0; cntm[i] = 0; prev[i] = 1'b0;
    end
    pat = 'b1011;
  endtask

  // One sample cycle: drive at the falling edge, check just after, then
  // advance the model to what the next rising edge will commit.
  task automatic step(input string ph, input bit e, input bit x, input bit ld, input int p);
    bit hit[4];
    @(negedge clock);
    en = e; x_in = x; pat_load = ld; pat_in = p[3:0];
    #1;
    for (int i = 0; i < 4; i++)
      hit[i] = e && !ld && (hl[i] == N - 1) && (int'(hv[i] * 2 + x) == pat);
    check_outputs(ph, hit);
    for (int i = 0; i < 4; i++) begin
      if (ld) begin
        hv[i] = 0; hl[i] = 0;
      end else if (e) begin
        if (hit[i] && !overlaps(i)) begin
          hv[i] = 0; hl[i] = 0;
        end else begin
          hv[i] = (hv[i] * 2 + x) % (1 << (N - 1));
          hl[i] = (hl[i] < N - 1) ? hl[i] + 1 : N - 1;
        end
      end
      if (hit[i] && cntm[i] < cnt_max(i)) cntm[i]++;
      prev[i] = hit[i];
    end
    if (ld) pat = p;
  endtask

  // Assert reset between clock edges and check that outputs clear at once.
  task automatic async_reset(input string ph);
    bit nohit[4];
    @(negedge clock);
    #2;
    reset = 1'b0;
    en = 1'b0; pat_load = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) nohit[i] = 1'b0;
    check_outputs(ph, nohit);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic stream(input string ph, input int bits, input int len);
    for (int k = len - 1; k >= 0; k--) step(ph, 1'b1, bits[k], 1'b0, 0);
  endtask

  initial begin
    async_reset("reset");

    stream("overlap", 'b1011011, 7);
    step("idle", 1'b0, 1'b0, 1'b0, 0);
    step("idle", 1'b0, 1'b1, 1'b0, 0);

    async_reset("reset2");
    stream("en_gap", 'b10, 2);
    for (int k = 0; k < 3; k++) step("en_gap", 1'b0, k[0], 1'b0, 0);
    stream("en_gap", 'b11, 2);
    step("idle", 1'b0, 1'b0, 1'b0, 0);

    async_reset("reset3");
    stream("reload", 'b101, 3);
    step("reload", 1'b1, 1'b1, 1'b1, 'b0110);
    stream("reload", 'b0110, 4);
    step("reload", 1'b1, 1'b1, 1'b1, 'b1011);

    for (int r = 0; r < 6; r++) stream("saturate", 'b1011, 4);
    stream("saturate", 'b10, 2);
    async_reset("midreset");
    stream("pat_back", 'b1011, 4);
    step("idle", 1'b0, 1'b0, 1'b0, 0);

    for (int c = 0; c < 600; c++) begin
      step("random", ($urandom % 4) != 0, $urandom % 2, ($urandom % 40) == 0, $urandom % 16);
      if ((c % 200) == 150) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
